// File: rtl/yrv_irq_seq.sv
// Interrupt entry sequencer: arbitrates nmi/li/ei/tmr/sw and runs a trap req/ack handshake with the core.
// One cycle from an eligible request to trap_req; a missing ack is abandoned after TMO_CYC cycles.
module yrv_irq_seq #(
  parameter logic [6:0] SW_CODE  = 7'd3,
  parameter logic [6:0] TMR_CODE = 7'd7,
  parameter logic [6:0] EI_CODE  = 7'd11,
  parameter logic [6:0] NMI_CODE = 7'd0,
  parameter int         TMO_CYC  = 64
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [4:0] irq_bus,
  input  logic [6:0] mli_code,
  input  logic       trap_inhibit,
  input  logic       wfi_state,
  input  logic       trap_ack,
  output logic       trap_req,
  output logic [6:0] trap_cause,
  output logic       trap_nmi,
  output logic [4:0] iack_bus,
  output logic       iack_nmi,
  output logic       wfi_wake,
  output logic       tmo_err
);

  localparam int            CW       = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [4:0]    src;
  logic [CW-1:0] cnt;
  logic          eligible;
  logic          src_live;
  logic [4:0]    win_src;
  logic [6:0]    win_cause;

  // Fixed priority nmi > li > ei > tmr > sw
  always_comb begin
    win_src   = 5'b00000;
    win_cause = SW_CODE;
    if (irq_bus[4]) begin
      win_src   = 5'b10000;
      win_cause = NMI_CODE;
    end else if (irq_bus[3]) begin
      win_src   = 5'b01000;
      win_cause = mli_code;
    end else if (irq_bus[2]) begin
      win_src   = 5'b00100;
      win_cause = EI_CODE;
    end else if (irq_bus[1]) begin
      win_src   = 5'b00010;
      win_cause = TMR_CODE;
    end else if (irq_bus[0]) begin
      win_src   = 5'b00001;
      win_cause = SW_CODE;
    end
  end

  assign eligible = irq_bus[4] | ((|irq_bus[3:0]) & ~trap_inhibit);
  assign src_live = |(src & irq_bus);
  assign trap_nmi = src[4];
  assign iack_nmi = iack_bus[4];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      src        <= 5'b00000;
      cnt        <= '0;
      trap_req   <= 1'b0;
      trap_cause <= 7'd0;
      iack_bus   <= 5'b00000;
      wfi_wake   <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      iack_bus <= 5'b00000;
      wfi_wake <= 1'b0;
      case (state)
        IDLE: begin
          if (eligible) begin
            src        <= win_src;
            trap_cause <= win_cause;
            trap_req   <= 1'b1;
            cnt        <= '0;
            wfi_wake   <= wfi_state;
            state      <= REQ;
          end
        end
        REQ: begin
          if (trap_ack) begin
            trap_req <= 1'b0;
            iack_bus <= src;
            state    <= DONE;
          end else if (irq_bus[4] && !src[4]) begin
            src        <= 5'b10000;
            trap_cause <= NMI_CODE;
            cnt        <= '0;
          end else if (!src[4] && (!src_live || trap_inhibit)) begin
            // Source vanished or became masked: withdraw silently, no ack pulse
            trap_req <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_LAST) begin
            trap_req <= 1'b0;
            tmo_err  <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (src[3]) trap_cause <= mli_code;
          end
        end
        DONE: begin
          // Dead cycle lets the source block clear its pending bit before re-arbitration
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yrv_irq_seq.sv
// Directed bench for yrv_irq_seq: a transaction-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_yrv_irq_seq;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       resetb;
  logic [4:0] irq_bus;
  logic [6:0] mli_code;
  logic       trap_inhibit;
  logic       wfi_state;
  logic       trap_ack;
  logic       trap_req;
  logic [6:0] trap_cause;
  logic       trap_nmi;
  logic [4:0] iack_bus;
  logic       iack_nmi;
  logic       wfi_wake;
  logic       tmo_err;

  int n_checks = 0;
  int n_errors = 0;

  yrv_irq_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .resetb(resetb), .irq_bus(irq_bus), .mli_code(mli_code),
    .trap_inhibit(trap_inhibit), .wfi_state(wfi_state), .trap_ack(trap_ack),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_nmi(trap_nmi),
    .iack_bus(iack_bus), .iack_nmi(iack_nmi), .wfi_wake(wfi_wake), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request identified by source index (-1 = none)
  int         m_src;
  int         m_age;
  bit         m_req, m_done, m_wake, m_tmo;
  logic [4:0] m_iack;
  logic [6:0] m_cause;

  function automatic logic [6:0] code_of(input int s, input logic [6:0] mli);
    case (s)
      4: return 7'd0;
      3: return mli;
      2: return 7'd11;
      1: return 7'd7;
      default: return 7'd3;
    endcase
  endfunction

  function automatic int top_src(input logic [4:0] b);
    for (int i = 4; i >= 0; i--) if (b[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_src = -1; m_age = 0; m_req = 0; m_done = 0;
      m_wake = 0; m_tmo = 0; m_iack = '0; m_cause = 7'd0;
    end else begin
      m_iack = '0;
      m_wake = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_req) begin
        if (irq_bus[4] || (irq_bus[3:0] != 0 && !trap_inhibit)) begin
          m_src = top_src(irq_bus);
          m_cause = code_of(m_src, mli_code);
          m_req = 1; m_age = 0; m_wake = wfi_state;
        end
      end else if (trap_ack) begin
        m_iack = 5'(1 << m_src);
        m_req = 0; m_done = 1;
      end else if (irq_bus[4] && m_src != 4) begin
        m_src = 4; m_cause = 7'd0; m_age = 0;
      end else if (m_src != 4 && (!irq_bus[m_src] || trap_inhibit)) begin
        m_req = 0;
      end else if (m_age + 1 == TMO) begin
        m_req = 0; m_tmo = 1;
      end else begin
        m_age++;
        if (m_src == 3) m_cause = mli_code;
      end
    end
  end

  always @(negedge clk) begin
    if (resetb === 1'b1) begin
      chk("model trap_req", 32'(trap_req), 32'(m_req));
      chk("model iack_bus", 32'(iack_bus), 32'(m_iack));
      chk("model iack_nmi", 32'(iack_nmi), 32'(m_iack[4]));
      chk("model wfi_wake", 32'(wfi_wake), 32'(m_wake));
      chk("model tmo_err", 32'(tmo_err), 32'(m_tmo));
      if (m_req) begin
        chk("model trap_cause", 32'(trap_cause), 32'(m_cause));
        chk("model trap_nmi", 32'(trap_nmi), 32'(m_src == 4));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetb = 1'b0; irq_bus = '0; mli_code = '0; trap_inhibit = 0; wfi_state = 0; trap_ack = 0;
    cyc(2);
    chk("rst trap_req", 32'(trap_req), 0);
    chk("rst trap_cause", 32'(trap_cause), 0);
    chk("rst iack_bus", 32'(iack_bus), 0);
    chk("rst tmo_err", 32'(tmo_err), 0);
    resetb = 1'b1;
    cyc();

    // sw+tmr together: tmr wins, ack after two request cycles
    irq_bus = 5'b00011; cyc();
    chk("swtmr req", 32'(trap_req), 1);
    chk("swtmr cause", 32'(trap_cause), 7);
    cyc();
    trap_ack = 1; cyc();
    chk("swtmr iack", 32'(iack_bus), 5'b00010);
    chk("swtmr req drop", 32'(trap_req), 0);
    trap_ack = 0; irq_bus = 5'b00001; cyc();
    chk("done no arb", 32'(trap_req), 0);
    chk("done iack clr", 32'(iack_bus), 0);
    cyc();
    chk("sw req", 32'(trap_req), 1);
    chk("sw cause", 32'(trap_cause), 3);
    trap_ack = 1; cyc();
    chk("sw iack", 32'(iack_bus), 5'b00001);
    trap_ack = 0; irq_bus = '0; cyc(2);

    // li with tracking mli_code, then NMI pre-empts
    irq_bus = 5'b01000; mli_code = 7'd18; cyc();
    chk("li cause", 32'(trap_cause), 18);
    chk("li nmi flag", 32'(trap_nmi), 0);
    mli_code = 7'd20; cyc();
    chk("li track", 32'(trap_cause), 20);
    irq_bus = 5'b11000; cyc();
    chk("nmi preempt cause", 32'(trap_cause), 0);
    chk("nmi preempt flag", 32'(trap_nmi), 1);
    trap_ack = 1; cyc();
    chk("nmi iack", 32'(iack_bus), 5'b10000);
    chk("iack_nmi", 32'(iack_nmi), 1);
    trap_ack = 0; irq_bus = '0; cyc(2);

    // ei withdrawn before ack
    irq_bus = 5'b00100; cyc();
    chk("ei cause", 32'(trap_cause), 11);
    irq_bus = '0; cyc();
    chk("ei withdraw req", 32'(trap_req), 0);
    chk("ei withdraw iack", 32'(iack_bus), 0);
    chk("ei withdraw tmo", 32'(tmo_err), 0);
    cyc();

    // trap_inhibit blocks maskable, not NMI
    trap_inhibit = 1; irq_bus = 5'b00010; cyc(2);
    chk("inhibit tmr", 32'(trap_req), 0);
    irq_bus = 5'b10010; cyc();
    chk("inhibit nmi req", 32'(trap_req), 1);
    chk("inhibit nmi cause", 32'(trap_cause), 0);
    trap_ack = 1; cyc();
    trap_ack = 0; irq_bus = '0; trap_inhibit = 0; cyc(2);
    irq_bus = 5'b00010; cyc();
    trap_inhibit = 1; cyc();
    chk("inhibit in req", 32'(trap_req), 0);
    trap_inhibit = 0; irq_bus = '0; cyc(2);

    // wake from WFI
    wfi_state = 1; irq_bus = 5'b00100; cyc();
    chk("wfi wake", 32'(wfi_wake), 1);
    chk("wfi req", 32'(trap_req), 1);
    cyc();
    chk("wfi wake pulse", 32'(wfi_wake), 0);
    trap_ack = 1; cyc();
    trap_ack = 0; irq_bus = '0; wfi_state = 0; cyc(2);

    // stray ack in IDLE
    trap_ack = 1; cyc();
    chk("stray ack iack", 32'(iack_bus), 0);
    trap_ack = 0; cyc();

    // NMI cannot be withdrawn
    irq_bus = 5'b10000; cyc();
    irq_bus = '0; cyc();
    chk("nmi held", 32'(trap_req), 1);
    trap_ack = 1; cyc();
    chk("nmi held iack", 32'(iack_bus), 5'b10000);
    trap_ack = 0; cyc(2);

    // timeout: four request cycles then drop
    irq_bus = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("tmo req high", 32'(trap_req), 1);
    end
    cyc();
    chk("tmo req drop", 32'(trap_req), 0);
    chk("tmo err", 32'(tmo_err), 1);
    chk("tmo no iack", 32'(iack_bus), 0);
    irq_bus = '0; cyc(2);
    chk("tmo sticky", 32'(tmo_err), 1);

    // asynchronous reset mid-REQ
    irq_bus = 5'b00100; cyc();
    chk("pre-rst req", 32'(trap_req), 1);
    #3 resetb = 1'b0;
    #1;
    chk("async rst req", 32'(trap_req), 0);
    chk("async rst cause", 32'(trap_cause), 0);
    chk("async rst tmo", 32'(tmo_err), 0);
    chk("async rst iack", 32'(iack_bus), 0);
    irq_bus = '0;
    cyc();
    resetb = 1'b1;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
